// File: rtl/hba_gpio_ng.sv
// -----------------------------------------------------------------------------
// hba_gpio_ng
//
// GPIO peripheral on the HBA slave bus. Each pin has an output-enable bit and
// an output value bit. Every pin's input passes through a two-flop
// synchroniser and a programmable debounce filter. Each pin can raise an
// interrupt on a rising edge, a falling edge, or both. Interrupt status is
// sticky and is cleared by writing 1 to the bit.
//
// Register map (offset = hba_abus[REG_ADDR_WIDTH-1:0]):
//   0 DIR          rw   1 = pin driven
//   1 OUT          rw   drive value
//   2 IN           ro   debounced pin value
//   3 INTR_EN      rw   per-pin interrupt enable
//   4 RISE_EN      rw   rising-edge select
//   5 FALL_EN      rw   falling-edge select
//   6 INTR_STATUS  w1c  sticky edge flags
//   7 DEBOUNCE     rw   filter threshold, full bus width
//   8+             reads 0, ignores writes, still acknowledged
//
// Ports:
//   hba_clk            bus clock; all logic on its rising edge
//   hba_reset_n        asynchronous active-low reset
//   hba_rnw            1 = read, 0 = write
//   hba_select         transfer in progress
//   hba_abus           {peripheral select, register offset}
//   hba_dbus           write data
//   hba_dbus_slave     read data; 0 except in the acknowledge cycle
//   hba_xferack_slave  one-cycle transfer acknowledge
//   slave_interrupt    level interrupt, OR of INTR_STATUS
//   gpio_out_en        per-pin output enable (DIR)
//   gpio_out_sig       per-pin output value (OUT)
//   gpio_in_sig        raw asynchronous pad inputs
// -----------------------------------------------------------------------------
module hba_gpio_ng #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_PINS          = 4
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  output logic [NUM_PINS-1:0]   gpio_out_en,
  output logic [NUM_PINS-1:0]   gpio_out_sig,
  input  logic [NUM_PINS-1:0]   gpio_in_sig
);

  localparam logic [PERIPH_ADDR_WIDTH-1:0] PERIPH_SEL = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);

  localparam logic [REG_ADDR_WIDTH-1:0] OFF_DIR         = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_OUT         = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_IN          = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_INTR_EN     = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_RISE_EN     = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_FALL_EN     = REG_ADDR_WIDTH'(5);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_INTR_STATUS = REG_ADDR_WIDTH'(6);
  localparam logic [REG_ADDR_WIDTH-1:0] OFF_DEBOUNCE    = REG_ADDR_WIDTH'(7);

  // configuration and status registers
  logic [NUM_PINS-1:0]   dir_q;
  logic [NUM_PINS-1:0]   out_q;
  logic [NUM_PINS-1:0]   intr_en_q;
  logic [NUM_PINS-1:0]   rise_en_q;
  logic [NUM_PINS-1:0]   fall_en_q;
  logic [NUM_PINS-1:0]   intr_status_q;
  logic [DBUS_WIDTH-1:0] debounce_q;

  // input path
  logic [NUM_PINS-1:0]   sync1_q;
  logic [NUM_PINS-1:0]   sync2_q;
  logic [NUM_PINS-1:0]   filt_q;
  logic [NUM_PINS-1:0]   prev_q;

  // bus decode
  logic                      xfer_start;
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] reg_off;
  logic [NUM_PINS-1:0]       wr_pins;
  logic [DBUS_WIDTH-1:0]     rd_data;

  // edge / status
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] status_set;
  logic [NUM_PINS-1:0] status_clr;

  function automatic logic [DBUS_WIDTH-1:0] zext_pins(input logic [NUM_PINS-1:0] v);
    logic [DBUS_WIDTH-1:0] r;
    r = '0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus decode. A transfer starts only while no acknowledge is outstanding,
  // which gives the mandatory idle cycle between back-to-back transfers.
  // ---------------------------------------------------------------------------
  assign reg_off    = hba_abus[REG_ADDR_WIDTH-1:0];
  assign xfer_start = hba_select
                   && (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_SEL)
                   && !hba_xferack_slave;
  assign wr_en      = xfer_start && !hba_rnw;
  assign wr_pins    = hba_dbus[NUM_PINS-1:0];

  // Read data always reflects register contents before the current edge.
  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_DIR:         rd_data = zext_pins(dir_q);
      OFF_OUT:         rd_data = zext_pins(out_q);
      OFF_IN:          rd_data = zext_pins(filt_q);
      OFF_INTR_EN:     rd_data = zext_pins(intr_en_q);
      OFF_RISE_EN:     rd_data = zext_pins(rise_en_q);
      OFF_FALL_EN:     rd_data = zext_pins(fall_en_q);
      OFF_INTR_STATUS: rd_data = zext_pins(intr_status_q);
      OFF_DEBOUNCE:    rd_data = debounce_q;
      default:         rd_data = '0;
    endcase
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      hba_xferack_slave <= 1'b0;
      hba_dbus_slave    <= '0;
    end else begin
      hba_xferack_slave <= xfer_start;
      hba_dbus_slave    <= xfer_start ? rd_data : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers. Writes to IN and to unmapped offsets fall
  // through the default arm and have no effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      dir_q      <= '0;
      out_q      <= '0;
      intr_en_q  <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      debounce_q <= '0;
    end else if (wr_en) begin
      case (reg_off)
        OFF_DIR:      dir_q      <= wr_pins;
        OFF_OUT:      out_q      <= wr_pins;
        OFF_INTR_EN:  intr_en_q  <= wr_pins;
        OFF_RISE_EN:  rise_en_q  <= wr_pins;
        OFF_FALL_EN:  fall_en_q  <= wr_pins;
        OFF_DEBOUNCE: debounce_q <= hba_dbus;
        default: ;
      endcase
    end
  end

  assign gpio_out_en  = dir_q;
  assign gpio_out_sig = out_q;

  // ---------------------------------------------------------------------------
  // Input path: synchroniser and edge-history registers for all pins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= gpio_in_sig;
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
    end
  end

  // Per-pin debounce. The counter measures how long the synchronised input
  // has disagreed with the filtered value. Comparing with >= means a
  // threshold lowered below the running count takes effect on the next edge.
  for (genvar p = 0; p < NUM_PINS; p++) begin : g_filt
    logic                  filt_bit;
    logic [DBUS_WIDTH-1:0] cnt;

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
        filt_bit <= 1'b0;
        cnt      <= '0;
      end else if (sync2_q[p] == filt_bit) begin
        cnt <= '0;
      end else if (cnt >= debounce_q) begin
        filt_bit <= sync2_q[p];
        cnt      <= '0;
      end else begin
        cnt <= cnt + DBUS_WIDTH'(1);
      end
    end

    assign filt_q[p] = filt_bit;
  end

  // ---------------------------------------------------------------------------
  // Edge detection and sticky status. A new event on a bit wins over a
  // write-1-to-clear of that bit on the same edge, so no event is lost.
  // ---------------------------------------------------------------------------
  assign rise       = filt_q & ~prev_q;
  assign fall       = ~filt_q & prev_q;
  assign status_set = intr_en_q & ((rise & rise_en_q) | (fall & fall_en_q));
  assign status_clr = (wr_en && (reg_off == OFF_INTR_STATUS)) ? wr_pins : '0;

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      intr_status_q <= '0;
    end else begin
      intr_status_q <= (intr_status_q & ~status_clr) | status_set;
    end
  end

  assign slave_interrupt = |intr_status_q;

endmodule

// File: tb/tb_hba_gpio_ng.sv
module tb_hba_gpio_ng;

  logic        hba_clk     = 1'b0;
  logic        hba_reset_n = 1'b0;
  logic        hba_rnw     = 1'b1;
  logic        hba_select  = 1'b0;
  logic [11:0] hba_abus    = '0;
  logic [7:0]  hba_dbus    = '0;
  logic [7:0]  hba_dbus_slave;
  logic        hba_xferack_slave;
  logic        slave_interrupt;
  logic [3:0]  gpio_out_en;
  logic [3:0]  gpio_out_sig;
  logic [3:0]  gpio_in_sig = '0;

  int   total  = 0;
  int   bad    = 0;
  bit   mon_on = 1'b0;
  logic [7:0] rdv;
  logic       ackv;

  hba_gpio_ng dut (
    .hba_clk           (hba_clk),
    .hba_reset_n       (hba_reset_n),
    .hba_rnw           (hba_rnw),
    .hba_select        (hba_select),
    .hba_abus          (hba_abus),
    .hba_dbus          (hba_dbus),
    .hba_dbus_slave    (hba_dbus_slave),
    .hba_xferack_slave (hba_xferack_slave),
    .slave_interrupt   (slave_interrupt),
    .gpio_out_en       (gpio_out_en),
    .gpio_out_sig      (gpio_out_sig),
    .gpio_in_sig       (gpio_in_sig)
  );

  always #5 hba_clk = ~hba_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: register file, bus handshake, and a debounce filter
  // expressed as "the last DEBOUNCE+1 synchronised samples all disagree
  // with the filtered value", using a pad-history queue.
  logic [3:0] m_dir, m_out, m_ien, m_ren, m_fen, m_st, m_filt, m_prev;
  logic [7:0] m_deb, m_rd;
  logic       m_ack;
  logic [3:0] hist[$];

  always @(posedge hba_clk or negedge hba_reset_n) begin : model
    logic       hit;
    logic [7:0] off, rd;
    logic [3:0] clr, set, nfilt;
    bit         flip;
    if (!hba_reset_n) begin
      m_dir = '0; m_out = '0; m_ien = '0; m_ren = '0; m_fen = '0;
      m_st = '0; m_filt = '0; m_prev = '0; m_deb = '0; m_rd = '0; m_ack = 1'b0;
      hist.delete();
      for (int i = 0; i < 16; i++) hist.push_back(4'h0);
    end else begin
      hist.push_front(gpio_in_sig);
      void'(hist.pop_back());
      hit = hba_select && (hba_abus[11:8] == 4'd0) && !m_ack;
      off = hba_abus[7:0];
      case (off)
        8'd0: rd = {4'h0, m_dir};
        8'd1: rd = {4'h0, m_out};
        8'd2: rd = {4'h0, m_filt};
        8'd3: rd = {4'h0, m_ien};
        8'd4: rd = {4'h0, m_ren};
        8'd5: rd = {4'h0, m_fen};
        8'd6: rd = {4'h0, m_st};
        8'd7: rd = m_deb;
        default: rd = 8'h00;
      endcase
      set = m_ien & ((m_filt & ~m_prev & m_ren) | (~m_filt & m_prev & m_fen));
      nfilt = m_filt;
      for (int p = 0; p < 4; p++) begin
        flip = 1'b1;
        for (int j = 0; j <= int'(m_deb); j++)
          if (hist[2+j][p] == m_filt[p]) flip = 1'b0;
        if (flip) nfilt[p] = ~m_filt[p];
      end
      clr = '0;
      if (hit && !hba_rnw) begin
        case (off)
          8'd0: m_dir = hba_dbus[3:0];
          8'd1: m_out = hba_dbus[3:0];
          8'd3: m_ien = hba_dbus[3:0];
          8'd4: m_ren = hba_dbus[3:0];
          8'd5: m_fen = hba_dbus[3:0];
          8'd6: clr   = hba_dbus[3:0];
          8'd7: m_deb = hba_dbus;
          default: ;
        endcase
      end
      m_st   = (m_st & ~clr) | set;
      m_prev = m_filt;
      m_filt = nfilt;
      m_ack  = hit;
      m_rd   = hit ? rd : 8'h00;
    end
  end

  always @(negedge hba_clk) begin
    if (mon_on) begin
      chk("mon_ack",  32'(hba_xferack_slave), 32'(m_ack));
      chk("mon_dbus", 32'(hba_dbus_slave),    32'(m_rd));
      chk("mon_oen",  32'(gpio_out_en),       32'(m_dir));
      chk("mon_osig", 32'(gpio_out_sig),      32'(m_out));
      chk("mon_irq",  32'(slave_interrupt),   32'(|m_st));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hba_clk);
    #1;
  endtask

  // Called just after a clock edge; returns #1 after the acknowledge edge.
  task automatic bus(input logic rnw, input logic [3:0] periph, input logic [7:0] off,
                     input logic [7:0] wd, output logic [7:0] rd, output logic ack);
    hba_select = 1'b1;
    hba_rnw    = rnw;
    hba_abus   = {periph, off};
    hba_dbus   = wd;
    ack = 1'b0;
    rd  = 8'h00;
    for (int i = 0; i < 4 && !ack; i++) begin
      @(posedge hba_clk);
      #1;
      if (hba_xferack_slave) begin
        ack = 1'b1;
        rd  = hba_dbus_slave;
      end
    end
    hba_select = 1'b0;
    hba_rnw    = 1'b1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    bus(1'b0, 4'h0, off, d, rdv, ackv);
    chk("wr_ack", 32'(ackv), 32'd1);
  endtask

  task automatic rd_exp(input string tag, input logic [7:0] off, input logic [7:0] exp);
    bus(1'b1, 4'h0, off, 8'h00, rdv, ackv);
    chk({tag, "_ack"}, 32'(ackv), 32'd1);
    chk(tag, 32'(rdv), 32'(exp));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] dv;
    repeat (3) @(posedge hba_clk);
    #1;
    hba_reset_n = 1'b1;
    mon_on = 1'b1;

    // reset state and readback
    chk("rst0_ack",  32'(hba_xferack_slave), 32'd0);
    chk("rst0_oen",  32'(gpio_out_en),       32'd0);
    chk("rst0_irq",  32'(slave_interrupt),   32'd0);
    for (int o = 0; o < 8; o++) rd_exp("rst_rd", 8'(o), 8'h00);
    wr(8'd0, 8'h0F);
    chk("dir_pin", 32'(gpio_out_en), 32'hF);
    wr(8'd1, 8'h05);
    chk("out_pin", 32'(gpio_out_sig), 32'h5);
    wr(8'd0, 8'hFF);
    rd_exp("dir_mask", 8'd0, 8'h0F);
    rd_exp("out_rd", 8'd1, 8'h05);
    wr(8'd2, 8'hFF);
    rd_exp("in_ro", 8'd2, 8'h00);
    wr(8'd8, 8'h55);
    rd_exp("off8", 8'd8, 8'h00);
    wr(8'd0, 8'h00);

    // handshake: select held three cycles
    tick(2);
    hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h001;
    tick(1); chk("hs_ack1", 32'(hba_xferack_slave), 32'd1);
    chk("hs_d1", 32'(hba_dbus_slave), 32'h05);
    tick(1); chk("hs_ack2", 32'(hba_xferack_slave), 32'd0);
    chk("hs_d2", 32'(hba_dbus_slave), 32'h00);
    tick(1); chk("hs_ack3", 32'(hba_xferack_slave), 32'd1);
    hba_select = 1'b0;
    tick(2);
    bus(1'b1, 4'h1, 8'd1, 8'h00, rdv, ackv);
    chk("wrong_ack", 32'(ackv), 32'd0);
    chk("wrong_dbus", 32'(hba_dbus_slave), 32'd0);

    // debounce = 4 on pin 2
    wr(8'd7, 8'd4); wr(8'd3, 8'h4); wr(8'd4, 8'h4);
    tick(2);
    gpio_in_sig = 4'h4; tick(3); gpio_in_sig = 4'h0; tick(12);
    rd_exp("glitch_in", 8'd2, 8'h00);
    rd_exp("glitch_st", 8'd6, 8'h00);
    gpio_in_sig = 4'h4;
    tick(7); chk("deb_early", 32'(slave_interrupt), 32'd0);
    tick(1); chk("deb_irq",   32'(slave_interrupt), 32'd1);
    gpio_in_sig = 4'h0;
    rd_exp("deb_in", 8'd2, 8'h04);
    tick(12);
    rd_exp("deb_in_low", 8'd2, 8'h00);
    rd_exp("deb_st", 8'd6, 8'h04);
    wr(8'd6, 8'h0F);
    rd_exp("w1c_all", 8'd6, 8'h00);

    // edge selection
    wr(8'd7, 8'd0); wr(8'd3, 8'h3); wr(8'd4, 8'h1); wr(8'd5, 8'h2); wr(8'd6, 8'h0F);
    gpio_in_sig = 4'h3; tick(5); gpio_in_sig = 4'h0; tick(5);
    rd_exp("edge_st", 8'd6, 8'h03);
    chk("edge_irq", 32'(slave_interrupt), 32'd1);
    wr(8'd6, 8'h01);
    rd_exp("w1c_one", 8'd6, 8'h02);

    // W1C on the same edge as a new pin0 rise
    tick(3);
    gpio_in_sig = 4'h1;
    tick(3);
    wr(8'd6, 8'h01);
    rd_exp("race_st", 8'd6, 8'h03);

    // async reset mid-count and mid-transfer
    wr(8'd0, 8'h0A); wr(8'd1, 8'h06); wr(8'd7, 8'd5);
    gpio_in_sig = 4'h8;
    tick(4);
    chk("pre_rst_irq", 32'(slave_interrupt), 32'd1);
    hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h002;
    #2 hba_reset_n = 1'b0;
    #1;
    chk("rst_ack",  32'(hba_xferack_slave), 32'd0);
    chk("rst_dbus", 32'(hba_dbus_slave),    32'd0);
    chk("rst_oen",  32'(gpio_out_en),       32'd0);
    chk("rst_osig", 32'(gpio_out_sig),      32'd0);
    chk("rst_irq",  32'(slave_interrupt),   32'd0);
    hba_select  = 1'b0;
    gpio_in_sig = 4'h0;
    #4 hba_reset_n = 1'b1;
    tick(1); chk("rst_noack1", 32'(hba_xferack_slave), 32'd0);
    tick(1); chk("rst_noack2", 32'(hba_xferack_slave), 32'd0);
    rd_exp("rst_in",  8'd2, 8'h00);
    rd_exp("rst_dir", 8'd0, 8'h00);
    rd_exp("rst_deb", 8'd7, 8'h00);

    // randomized traffic against the model
    dv = 8'($urandom_range(0, 3));
    wr(8'd7, dv);
    wr(8'd3, 8'($urandom));
    wr(8'd4, 8'($urandom));
    wr(8'd5, 8'($urandom));
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0)
        gpio_in_sig = gpio_in_sig ^ 4'(1 << $urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin
          bus(1'b1, 4'h0, 8'($urandom_range(0, 9)), 8'h00, rdv, ackv);
          chk("rnd_ack", 32'(ackv), 32'd1);
          chk("rnd_rd",  32'(rdv),  32'(m_rd));
        end
        1: wr(8'd6, 8'($urandom));
        2: wr(8'($urandom_range(0, 5)), 8'($urandom));
        default: tick(1);
      endcase
    end
    tick(2);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
